// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, post-reset zero sweep
// and a per-register pending scoreboard for hazard detection.
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int NRD       = 2,
    parameter int NWR       = 2,
    parameter int BYPASS    = 1,
    parameter int CLEAR_RST = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rd_pend,
    input  logic                pend_set,
    input  logic [AW-1:0]       pend_addr,
    output logic                busy
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;

    // x0 and addresses beyond the array are never stored, pended or read back
    function automatic logic valid(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            idx   <= '0;
            pend  <= '0;
        end else if (state == INIT) begin
            if (CLEAR_RST != 0) begin
                regs[idx] <= '0;
                if (idx == AW'(NREG - 1))
                    state <= READY;
                else
                    idx <= idx + AW'(1);
            end else begin
                state <= READY;
            end
        end else begin
            // ascending port order: the last matching port (highest index) wins
            for (int unsigned p = 0; p < NWR; p++) begin
                if (we[p] && valid(waddr[p*AW +: AW])) begin
                    regs[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
                    pend[waddr[p*AW +: AW]] <= 1'b0;
                end
            end
            // placed after the write clears so a new producer supersedes the old one
            if (pend_set && valid(pend_addr))
                pend[pend_addr] <= 1'b1;
        end
    end

    assign busy = (state == INIT);

    always_comb begin
        rdata   = '0;
        rd_pend = '0;
        for (int unsigned r = 0; r < NRD; r++) begin
            if (state == READY && valid(raddr[r*AW +: AW])) begin
                rdata[r*XLEN +: XLEN] = regs[raddr[r*AW +: AW]];
                rd_pend[r]            = pend[raddr[r*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int unsigned p = 0; p < NWR; p++) begin
                        if (we[p] && waddr[p*AW +: AW] == raddr[r*AW +: AW])
                            rdata[r*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (32 regs with bypass, 24 regs without) driven in
// parallel and checked every cycle against an array model plus directed literal checks.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rp_a, rp_b;
    logic        busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1), .CLEAR_RST(1)) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a), .rd_pend(rp_a), .pend_set(pend_set), .pend_addr(pend_addr), .busy(busy_a)
    );

    regfile_mp #(.XLEN(32), .NREG(24), .NRD(2), .NWR(2), .BYPASS(0), .CLEAR_RST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_b), .rd_pend(rp_b), .pend_set(pend_set), .pend_addr(pend_addr), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (index 0 = u_a, 1 = u_b) ----------------
    logic [31:0] mreg  [2][32];
    bit          mpend [2][32];
    int          left  [2] = '{0, 0};

    function automatic int nr(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit ok(input int k, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nr(k));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                left[k] = nr(k);
                for (int i = 0; i < 32; i++) begin
                    mreg[k][i]  = 32'd0;
                    mpend[k][i] = 1'b0;
                end
            end else if (left[k] > 0) begin
                left[k]--;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (we[p] && ok(k, waddr[p*5 +: 5])) begin
                        mreg[k][waddr[p*5 +: 5]]  = wdata[p*32 +: 32];
                        mpend[k][waddr[p*5 +: 5]] = 1'b0;
                    end
                if (pend_set && ok(k, pend_addr))
                    mpend[k][pend_addr] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int k, input int r);
        logic [4:0] a = raddr[r*5 +: 5];
        if (left[k] > 0 || !ok(k, a)) return 32'd0;
        if (k == 0)
            for (int p = 1; p >= 0; p--)
                if (we[p] && waddr[p*5 +: 5] == a) return wdata[p*32 +: 32];
        return mreg[k][a];
    endfunction

    function automatic logic [31:0] exp_rp(input int k, input int r);
        logic [4:0] a = raddr[r*5 +: 5];
        if (left[k] > 0 || !ok(k, a)) return 32'd0;
        return {31'd0, mpend[k][a]};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_a", {31'd0, busy_a}, {31'd0, left[0] > 0});
            check("busy_b", {31'd0, busy_b}, {31'd0, left[1] > 0});
            for (int r = 0; r < 2; r++) begin
                check($sformatf("rdata_a%0d", r), rdata_a[r*32 +: 32], exp_rd(0, r));
                check($sformatf("rdata_b%0d", r), rdata_b[r*32 +: 32], exp_rd(1, r));
                check($sformatf("rdpend_a%0d", r), {31'd0, rp_a[r]}, exp_rp(0, r));
                check($sformatf("rdpend_b%0d", r), {31'd0, rp_b[r]}, exp_rp(1, r));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = 2'b00;
        pend_set = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p]             = 1'b1;
        waddr[p*5 +: 5]   = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic count_busy(input string tag);
        int ca = 0;
        int cb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b) break;
        end
        check({tag, "_len_a"}, 32'(ca), 32'd32);
        check({tag, "_len_b"}, 32'(cb), 32'd24);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; idle(); waddr = '0; wdata = '0; raddr = '0; pend_addr = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        count_busy("sweep1");

        for (int a = 0; a < 32; a += 2) begin
            tick();
            raddr = {5'(a + 1), 5'(a)};
            @(negedge clk);
            check("zero_a", rdata_a[31:0] | rdata_a[63:32], 32'd0);
            check("zero_b", rdata_b[31:0] | rdata_b[63:32], 32'd0);
        end

        tick(); wr(0, 5'd3, 32'h1234); raddr = {5'd0, 5'd3};
        tick(); idle();
        @(negedge clk); check("x3_written", rdata_a[31:0], 32'h1234);

        // reset pulse while the sweep is at idx 10
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        count_busy("sweep2");
        tick(); raddr = {5'd0, 5'd3};
        @(negedge clk); check("x3_cleared", rdata_a[31:0], 32'd0);

        tick(); wr(0, 5'd5, 32'hDEADBEEF); raddr = {5'd0, 5'd5};
        @(negedge clk);
        check("bypass_a", rdata_a[31:0], 32'hDEADBEEF);
        check("nobypass_b", rdata_b[31:0], 32'd0);
        tick(); idle();
        @(negedge clk);
        check("x5_next_a", rdata_a[31:0], 32'hDEADBEEF);
        check("x5_next_b", rdata_b[31:0], 32'hDEADBEEF);

        tick(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); raddr = {5'd0, 5'd7};
        @(negedge clk); check("prio_bypass_a", rdata_a[31:0], 32'h22);
        tick(); idle();
        @(negedge clk);
        check("prio_a", rdata_a[31:0], 32'h22);
        check("prio_b", rdata_b[31:0], 32'h22);
        tick(); wr(0, 5'd0, 32'h55); raddr = {5'd0, 5'd0};
        @(negedge clk); check("x0_bypass_a", rdata_a[31:0], 32'd0);
        tick(); idle();
        @(negedge clk);
        check("x0_a", rdata_a[31:0], 32'd0);
        check("x0_b", rdata_b[31:0], 32'd0);

        tick(); wr(1, 5'd30, 32'hAB); raddr = {5'd30, 5'd0};
        @(negedge clk);
        check("x30_bypass_a", rdata_a[63:32], 32'hAB);
        check("x30_range_b", rdata_b[63:32], 32'd0);
        tick(); idle();
        @(negedge clk);
        check("x30_a", rdata_a[63:32], 32'hAB);
        check("x30_b", rdata_b[63:32], 32'd0);

        tick(); pend_set = 1'b1; pend_addr = 5'd9; raddr = {5'd9, 5'd0};
        @(negedge clk); check("pend_same_cycle", {31'd0, rp_a[1]}, 32'd0);
        tick(); idle();
        @(negedge clk);
        check("pend_set_a", {31'd0, rp_a[1]}, 32'd1);
        check("pend_set_b", {31'd0, rp_b[1]}, 32'd1);
        tick(); wr(1, 5'd9, 32'h99);
        @(negedge clk); check("pend_not_bypassed", {31'd0, rp_a[1]}, 32'd1);
        tick(); idle();
        @(negedge clk); check("pend_cleared", {31'd0, rp_a[1]}, 32'd0);
        tick(); pend_set = 1'b1; pend_addr = 5'd9; wr(0, 5'd9, 32'h77);
        tick(); idle();
        @(negedge clk);
        check("pend_set_wins", {31'd0, rp_a[1]}, 32'd1);
        check("x9_data", rdata_a[63:32], 32'h77);
        tick(); pend_set = 1'b1; pend_addr = 5'd0; raddr = {5'd9, 5'd0};
        tick(); idle();
        @(negedge clk); check("pend_x0", {31'd0, rp_a[0]}, 32'd0);

        for (int i = 0; i < 10000; i++) begin
            tick();
            we        = 2'($urandom);
            waddr     = 10'($urandom);
            wdata     = {$urandom, $urandom};
            raddr     = ($urandom_range(0, 1) == 0) ? waddr : 10'($urandom);
            pend_set  = ($urandom_range(0, 3) == 0);
            pend_addr = ($urandom_range(0, 1) == 0) ? raddr[4:0] : 5'($urandom);
            rst_n     = !(i >= 5000 && i < 5002);
        end
        tick(); idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
